rename_unit_ckpt: RTL and testbench
===================================

Name: rename_unit_ckpt

Overview:
- Parametrised register-renaming unit: speculative RAT, retirement RAT, and circular free list with speculative and retire read pointers.
- Renames one instruction per cycle behind a valid/ready handshake.
- Frees the previous mapping on in-order commit.
- On flush, recovers speculative state in one cycle from the retirement RAT.
- Sits between decoder and ROB/reservation stations.

Parameters:
ARCH_REGS, 32, number of architectural registers; arch reg 0 is hardwired zero
PHYS_REGS, 64, number of physical registers; must be > ARCH_REGS
ARCH_W, $clog2(ARCH_REGS), arch index width
PHYS_W, $clog2(PHYS_REGS), phys index width
FL_DEPTH, PHYS_REGS-ARCH_REGS, free-list capacity

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
rename_valid  in  1  decoder presents an instruction
rename_ready  out  1  unit accepts it this cycle
rename_has_dest  in  1  instruction writes a register
rename_src1, rename_src2, rename_dest  in  ARCH_W each  arch indices
phys_src1, phys_src2  out  PHYS_W each  current speculative mappings
phys_dest  out  PHYS_W  newly allocated reg (0 if no allocation)
phys_dest_old  out  PHYS_W  previous mapping of rename_dest (0 if no allocation)
commit_valid  in  1  ROB retires one instruction
commit_has_dest  in  1  retiring instruction wrote a register
commit_arch_dest  in  ARCH_W  its arch dest
commit_phys_dest  in  PHYS_W  its new phys reg
commit_phys_old  in  PHYS_W  reg to free
flush  in  1  mispredict/exception recovery
free_count  out  PHYS_W+1  registered number of free entries
overflow_err  out  1  sticky; set on push to full list or pop from empty list

Behaviour:
- Reset (reset==0, async): both RATs map arch i -> phys i.
- Reset: free list entry k = ARCH_REGS+k; spec_head=retire_head=tail=0; free_count=FL_DEPTH; overflow_err=0.
- Lookup is combinational from registered state: phys_src*, phys_dest, phys_dest_old are valid in the same cycle as rename_valid.
- All updates occur at posedge.
- rename_ready = !flush && free_count!=0. It does not depend on rename_valid.
- alloc = rename_valid && rename_ready && rename_has_dest && rename_dest!=0.
- When alloc:
  - phys_dest = list[spec_head]; phys_dest_old = specRAT[rename_dest].
  - Next edge: specRAT[rename_dest] <= phys_dest; spec_head advances.
- When not alloc: phys_dest = phys_dest_old = 0.
- Sources read the pre-update map, so src==dest yields the old mapping.
- Arch reg 0 always maps to phys 0. Phys 0 is never allocated or freed.
- Commit fires when commit_valid && commit_has_dest && commit_arch_dest!=0. On fire:
  - retRAT[commit_arch_dest] <= commit_phys_dest.
  - list[tail] <= commit_phys_old; tail advances.
  - retire_head advances.
- All pointers wrap FL_DEPTH-1 -> 0 (modulo, no power-of-two requirement).
- free_count next = free_count − alloc + commit_fire.
- Simultaneous rename and commit: count is net, so a full list stays full. A reg freed this cycle is not renamable until the next cycle (no bypass).
- Flush:
  - rename is ignored (ready=0).
  - Next edge: specRAT <= retRAT, including any same-cycle commit; spec_head <= retire_head, including any same-cycle advance.
  - free_count <= (tail − retire_head) mod FL_DEPTH after the commit, with the full case tracked by count.
  - Recovery takes one cycle; rename_ready is valid again the following cycle.
- Commit fire when free_count==FL_DEPTH sets overflow_err; state must not corrupt. Same for alloc at 0, which is unreachable via ready.
- overflow_err clears only on reset.
- Reset asserted mid-operation discards all in-flight state immediately.

Decomposition:
- rename_pkg:
  - default ARCH_REGS/PHYS_REGS localparams;
  - rename_req_t struct {has_dest, src1, src2, dest};
  - rename_rsp_t struct {src1, src2, dest, dest_old};
  - commit_t struct.
- Sub-module rename_free_list (circular buffer, spec_head, retire_head, tail, count, flush restore, overflow_err).
- RATs stay in the top.

Test Plan:
- Reset, then rename src1=3, src2=4, dest=5 -> phys_src1=3, phys_src2=4, phys_dest=32, phys_dest_old=5; next rename of dest 5 -> dest=33, dest_old=32; free_count 32->30.
- Rename dest=0 with has_dest=1 -> phys_dest=0, dest_old=0; free_count unchanged.
- 32 back-to-back allocs -> rename_ready=0 at free_count 0; commit phys_old=5 -> free_count 1, ready=1, next alloc returns 5 after the pointer wraps.
- Alloc to arch 7 (phys 32), then 7 (33), then commit the first (old 7), then flush -> specRAT[7]=32; next alloc returns 33; free_count=31.
- Commit and flush in same cycle -> retRAT and specRAT both hold the committed mapping; free_count includes the freed reg.
- Assert reset mid-stream with 10 allocs outstanding -> identity map, free_count=32, overflow_err=0; commit while list full -> overflow_err=1 and stays set.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared definitions for the register-renaming unit: default sizes,
// request/response/commit records and a modulo pointer helper.
package rename_pkg;

  localparam int unsigned DEF_ARCH_REGS = 32;
  localparam int unsigned DEF_PHYS_REGS = 64;
  localparam int unsigned DEF_ARCH_W    = $clog2(DEF_ARCH_REGS);
  localparam int unsigned DEF_PHYS_W    = $clog2(DEF_PHYS_REGS);

  typedef struct packed {
    logic                  has_dest;
    logic [DEF_ARCH_W-1:0] src1;
    logic [DEF_ARCH_W-1:0] src2;
    logic [DEF_ARCH_W-1:0] dest;
  } rename_req_t;

  typedef struct packed {
    logic [DEF_PHYS_W-1:0] src1;
    logic [DEF_PHYS_W-1:0] src2;
    logic [DEF_PHYS_W-1:0] dest;
    logic [DEF_PHYS_W-1:0] dest_old;
  } rename_rsp_t;

  typedef struct packed {
    logic                  valid;
    logic                  has_dest;
    logic [DEF_ARCH_W-1:0] arch_dest;
    logic [DEF_PHYS_W-1:0] phys_dest;
    logic [DEF_PHYS_W-1:0] phys_old;
  } commit_t;

  // Advance a circular pointer, wrapping depth-1 -> 0 for any depth.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers. spec_head feeds speculative
// allocation, retire_head follows in-order commit, tail receives freed
// registers. A flush rewinds spec_head to the (post-commit) retire_head.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int unsigned ARCH_REGS = DEF_ARCH_REGS,
  parameter int unsigned PHYS_W    = DEF_PHYS_W,
  parameter int unsigned FL_DEPTH  = DEF_PHYS_REGS - DEF_ARCH_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pop,
  input  logic              push,
  input  logic [PHYS_W-1:0] push_data,
  input  logic              flush,
  output logic [PHYS_W-1:0] head_data,
  output logic [PHYS_W:0]   count,
  output logic              push_accept,
  output logic              overflow_err
);

  localparam int unsigned    PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam logic [PHYS_W:0] FULL = (PHYS_W + 1)'(FL_DEPTH);

  logic [PHYS_W-1:0] mem [FL_DEPTH];
  logic [PTR_W-1:0]  spec_head, retire_head, tail;
  logic [PTR_W-1:0]  spec_head_next, retire_head_next, tail_next;
  logic [PHYS_W:0]   count_next, restore_count;
  logic              pop_ok, push_ok, overflow_now;
  int unsigned       restore_diff;

  assign head_data   = mem[spec_head];
  assign push_accept = push_ok;

  // Next-state pointers/count; a push into a full list is dropped unless a
  // same-cycle pop makes room, and a flush recounts from the retire view.
  always_comb begin
    pop_ok       = pop && (count != '0);
    push_ok      = push && ((count != FULL) || pop_ok);
    overflow_now = (pop && (count == '0)) || (push && !push_ok);

    tail_next        = push_ok ? PTR_W'(ptr_inc(32'(tail), FL_DEPTH)) : tail;
    retire_head_next = push_ok ? PTR_W'(ptr_inc(32'(retire_head), FL_DEPTH)) : retire_head;

    // Equal pointers on the retire side always mean a full list: every
    // architecturally free register is held between retire_head and tail.
    restore_diff  = (32'(tail_next) + FL_DEPTH - 32'(retire_head_next)) % FL_DEPTH;
    restore_count = (restore_diff == 0) ? FULL : (PHYS_W + 1)'(restore_diff);

    if (flush) begin
      spec_head_next = retire_head_next;
      count_next     = restore_count;
    end else begin
      spec_head_next = pop_ok ? PTR_W'(ptr_inc(32'(spec_head), FL_DEPTH)) : spec_head;
      count_next     = count + (PHYS_W + 1)'(push_ok) - (PHYS_W + 1)'(pop_ok);
    end
  end

  // Storage, pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < FL_DEPTH; k++) begin
        mem[k] <= PHYS_W'(ARCH_REGS + k);
      end
      spec_head    <= '0;
      retire_head  <= '0;
      tail         <= '0;
      count        <= FULL;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[tail] <= push_data;
      end
      spec_head   <= spec_head_next;
      retire_head <= retire_head_next;
      tail        <= tail_next;
      count       <= count_next;
      if (overflow_now) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_unit_ckpt.sv
// Register-renaming unit: speculative and retirement RATs plus a free list.
// Renames one instruction per cycle, frees old mappings on commit and
// restores speculative state from the retirement RAT on flush.
module rename_unit_ckpt
  import rename_pkg::*;
#(
  parameter int unsigned ARCH_REGS = DEF_ARCH_REGS,
  parameter int unsigned PHYS_REGS = DEF_PHYS_REGS,
  parameter int unsigned ARCH_W    = $clog2(ARCH_REGS),
  parameter int unsigned PHYS_W    = $clog2(PHYS_REGS),
  parameter int unsigned FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rename_valid,
  output logic              rename_ready,
  input  logic              rename_has_dest,
  input  logic [ARCH_W-1:0] rename_src1,
  input  logic [ARCH_W-1:0] rename_src2,
  input  logic [ARCH_W-1:0] rename_dest,
  output logic [PHYS_W-1:0] phys_src1,
  output logic [PHYS_W-1:0] phys_src2,
  output logic [PHYS_W-1:0] phys_dest,
  output logic [PHYS_W-1:0] phys_dest_old,
  input  logic              commit_valid,
  input  logic              commit_has_dest,
  input  logic [ARCH_W-1:0] commit_arch_dest,
  input  logic [PHYS_W-1:0] commit_phys_dest,
  input  logic [PHYS_W-1:0] commit_phys_old,
  input  logic              flush,
  output logic [PHYS_W:0]   free_count,
  output logic              overflow_err
);

  logic [PHYS_W-1:0] spec_rat     [ARCH_REGS];
  logic [PHYS_W-1:0] ret_rat      [ARCH_REGS];
  logic [PHYS_W-1:0] ret_rat_next [ARCH_REGS];
  logic [PHYS_W-1:0] head_data;
  logic              alloc, commit_fire, commit_accept;

  assign rename_ready = !flush && (free_count != '0);

  // Lookups and allocation decode from registered state.
  always_comb begin
    alloc         = rename_valid && rename_ready && rename_has_dest && (rename_dest != '0);
    commit_fire   = commit_valid && commit_has_dest && (commit_arch_dest != '0);
    phys_src1     = spec_rat[rename_src1];
    phys_src2     = spec_rat[rename_src2];
    phys_dest     = alloc ? head_data : '0;
    phys_dest_old = alloc ? spec_rat[rename_dest] : '0;
  end

  // Retirement map including this cycle's commit, so a flush sees it too.
  always_comb begin
    ret_rat_next = ret_rat;
    if (commit_accept) begin
      ret_rat_next[commit_arch_dest] = commit_phys_dest;
    end
  end

  // Both RATs: identity on reset, flush copies the updated retirement map.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= PHYS_W'(i);
        ret_rat[i]  <= PHYS_W'(i);
      end
    end else begin
      ret_rat <= ret_rat_next;
      if (flush) begin
        spec_rat <= ret_rat_next;
      end else if (alloc) begin
        spec_rat[rename_dest] <= head_data;
      end
    end
  end

  rename_free_list #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_W    (PHYS_W),
    .FL_DEPTH  (FL_DEPTH)
  ) u_free_list (
    .clk          (clk),
    .reset        (reset),
    .pop          (alloc),
    .push         (commit_fire),
    .push_data    (commit_phys_old),
    .flush        (flush),
    .head_data    (head_data),
    .count        (free_count),
    .push_accept  (commit_accept),
    .overflow_err (overflow_err)
  );

endmodule

// File: tb/tb_rename_unit_ckpt.sv
// Bench for rename_unit_ckpt: a directed vector table, hand sequences for
// fill/wrap, flush recovery, reset and overflow, then random traffic, all
// compared against an unbounded-queue reference model.
module tb_rename_unit_ckpt;
  import rename_pkg::*;

  localparam int NA  = 32;
  localparam int FLD = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       rename_valid, rename_ready, rename_has_dest;
  logic [4:0] rename_src1, rename_src2, rename_dest;
  logic [5:0] phys_src1, phys_src2, phys_dest, phys_dest_old;
  logic       commit_valid, commit_has_dest;
  logic [4:0] commit_arch_dest;
  logic [5:0] commit_phys_dest, commit_phys_old;
  logic       flush;
  logic [6:0] free_count;
  logic       overflow_err;

  always #5 clk = ~clk;

  rename_unit_ckpt #(.ARCH_REGS(32), .PHYS_REGS(64)) dut (
    .clk(clk), .reset(reset),
    .rename_valid(rename_valid), .rename_ready(rename_ready),
    .rename_has_dest(rename_has_dest),
    .rename_src1(rename_src1), .rename_src2(rename_src2), .rename_dest(rename_dest),
    .phys_src1(phys_src1), .phys_src2(phys_src2),
    .phys_dest(phys_dest), .phys_dest_old(phys_dest_old),
    .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
    .commit_arch_dest(commit_arch_dest), .commit_phys_dest(commit_phys_dest),
    .commit_phys_old(commit_phys_old), .flush(flush),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  // ---------------- reference model ----------------
  // The free list is an ever-growing queue of every register that has been
  // made free; spec/retire positions are plain absolute indices into it.
  typedef struct { int arch; int np; int op; } rob_t;
  int   smap [NA];
  int   rmap [NA];
  int   q [$];
  int   sidx, ridx;
  bit   merr;
  rob_t rob [$];

  bit p_alloc, p_accept, p_err, p_flush;
  int p_dest, p_np, p_op, p_ca, p_cp, p_co;

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin smap[i] = i; rmap[i] = i; end
    q.delete();
    for (int k = 0; k < FLD; k++) q.push_back(NA + k);
    sidx = 0; ridx = 0; merr = 0;
    rob.delete();
  endtask

  // Apply inputs, then compare every output against the model prediction.
  task automatic drive(input bit v, input bit hd, input int s1, input int s2, input int d,
                       input bit cv, input bit chd, input int ca, input int cp, input int co,
                       input bit fl);
    int cnt;
    bit rdy, fire;
    rename_rsp_t e;
    rename_valid = v; rename_has_dest = hd;
    rename_src1 = 5'(s1); rename_src2 = 5'(s2); rename_dest = 5'(d);
    commit_valid = cv; commit_has_dest = chd; commit_arch_dest = 5'(ca);
    commit_phys_dest = 6'(cp); commit_phys_old = 6'(co); flush = fl;
    #1;
    cnt      = q.size() - sidx;
    rdy      = !fl && (cnt != 0);
    p_alloc  = v && rdy && hd && (d != 0);
    fire     = cv && chd && (ca != 0);
    p_accept = fire && ((cnt != FLD) || p_alloc);
    p_err    = fire && !p_accept;
    p_flush  = fl;
    p_dest = d; p_ca = ca; p_cp = cp; p_co = co;
    p_np   = p_alloc ? q[sidx] : 0;
    p_op   = p_alloc ? smap[d] : 0;
    e.src1 = 6'(smap[s1]); e.src2 = 6'(smap[s2]);
    e.dest = 6'(p_np);     e.dest_old = 6'(p_op);
    chk("ready",     32'(rename_ready),  32'(rdy));
    chk("src1",      32'(phys_src1),     32'(e.src1));
    chk("src2",      32'(phys_src2),     32'(e.src2));
    chk("dest",      32'(phys_dest),     32'(e.dest));
    chk("dest_old",  32'(phys_dest_old), 32'(e.dest_old));
    chk("count",     32'(free_count),    32'(cnt));
    chk("overflow",  32'(overflow_err),  32'(merr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (p_accept) begin
        rmap[p_ca] = p_cp;
        q.push_back(p_co);
        ridx++;
        if (rob.size() > 0) rob.delete(0);
      end
      if (p_alloc) begin
        smap[p_dest] = p_np;
        rob.push_back('{p_dest, p_np, p_op});
        sidx++;
      end
      if (p_err) merr = 1;
      if (p_flush) begin
        smap = rmap;
        sidx = ridx;
        rob.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ren(input int s1, input int s2, input int d);
    drive(1, 1, s1, s2, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    idle();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit v, hd; int s1, s2, d;
    bit cv, chd; int ca, cp, co; bit fl;
    bit e_rdy; int e_s1, e_s2, e_d, e_old, e_cnt;
  } vec_t;

  function automatic vec_t mk(bit v, bit hd, int s1, int s2, int d,
                              bit cv, bit chd, int ca, int cp, int co, bit fl,
                              bit e_rdy, int e_s1, int e_s2, int e_d, int e_old, int e_cnt);
    vec_t r;
    r.v = v; r.hd = hd; r.s1 = s1; r.s2 = s2; r.d = d;
    r.cv = cv; r.chd = chd; r.ca = ca; r.cp = cp; r.co = co; r.fl = fl;
    r.e_rdy = e_rdy; r.e_s1 = e_s1; r.e_s2 = e_s2; r.e_d = e_d; r.e_old = e_old; r.e_cnt = e_cnt;
    return r;
  endfunction

  vec_t vt [10];

  initial begin
    int v, hd, s1, s2, d, cv, chd, ca, cp, co, fl;

    reset = 1'b0;
    model_reset();
    rename_valid = 0; rename_has_dest = 0; rename_src1 = '0; rename_src2 = '0; rename_dest = '0;
    commit_valid = 0; commit_has_dest = 0; commit_arch_dest = '0;
    commit_phys_dest = '0; commit_phys_old = '0; flush = 0;
    repeat (2) @(negedge clk);
    chk("reset_count", 32'(free_count), 32);
    chk("reset_err",   32'(overflow_err), 0);
    reset = 1'b1;

    //          v hd s1 s2 d  cv chd ca cp co fl  rdy s1 s2 d  old cnt
    vt[0] = mk(1, 1, 3, 4, 5,  0, 0, 0, 0, 0, 0,  1,  3, 4, 32, 5, 32);
    vt[1] = mk(1, 1, 5, 0, 5,  0, 0, 0, 0, 0, 0,  1, 32, 0, 33, 32, 31);
    vt[2] = mk(1, 1, 5, 1, 0,  0, 0, 0, 0, 0, 0,  1, 33, 1, 0, 0, 30);
    vt[3] = mk(1, 0, 5, 6, 6,  0, 0, 0, 0, 0, 0,  1, 33, 6, 0, 0, 30);
    vt[4] = mk(0, 0, 5, 0, 0,  0, 0, 0, 0, 0, 0,  1, 33, 0, 0, 0, 30);
    vt[5] = mk(1, 1, 9, 5, 9,  1, 1, 5, 32, 5, 0, 1,  9, 33, 34, 9, 30);
    vt[6] = mk(1, 1, 9, 5, 9,  0, 0, 0, 0, 0, 1,  0, 34, 33, 0, 0, 30);
    vt[7] = mk(1, 1, 5, 9, 9,  0, 0, 0, 0, 0, 0,  1, 32, 9, 33, 9, 32);
    vt[8] = mk(0, 0, 9, 0, 0,  1, 0, 3, 50, 3, 0, 1, 33, 0, 0, 0, 31);
    vt[9] = mk(0, 0, 3, 0, 0,  0, 0, 0, 0, 0, 0,  1,  3, 0, 0, 0, 31);

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].v, vt[i].hd, vt[i].s1, vt[i].s2, vt[i].d,
            vt[i].cv, vt[i].chd, vt[i].ca, vt[i].cp, vt[i].co, vt[i].fl);
      chk($sformatf("vec%0d_ready", i), 32'(rename_ready),  32'(vt[i].e_rdy));
      chk($sformatf("vec%0d_src1", i),  32'(phys_src1),     32'(vt[i].e_s1));
      chk($sformatf("vec%0d_src2", i),  32'(phys_src2),     32'(vt[i].e_s2));
      chk($sformatf("vec%0d_dest", i),  32'(phys_dest),     32'(vt[i].e_d));
      chk($sformatf("vec%0d_old", i),   32'(phys_dest_old), 32'(vt[i].e_old));
      chk($sformatf("vec%0d_count", i), 32'(free_count),    32'(vt[i].e_cnt));
      tick();
    end

    // Fill the list, stall, free one register and see it reappear after wrap.
    do_reset();
    ren(0, 0, 5);
    chk("fill_first_dest", 32'(phys_dest), 32);
    tick();
    for (int i = 1; i < 32; i++) begin ren(0, 0, (i % 31) + 1); tick(); end
    drive(1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    chk("full_ready", 32'(rename_ready), 0);
    chk("full_count", 32'(free_count), 0);
    chk("full_dest",  32'(phys_dest), 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1, 5, 32, 5, 0);
    tick();
    ren(0, 0, 3);
    chk("wrap_ready", 32'(rename_ready), 1);
    chk("wrap_count", 32'(free_count), 1);
    chk("wrap_dest",  32'(phys_dest), 5);
    tick();

    // Two allocs to arch 7, commit the first, flush: recover to the first.
    do_reset();
    ren(0, 0, 7); tick();
    ren(0, 0, 7); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 7, 32, 7, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    ren(7, 0, 8);
    chk("flush_src7", 32'(phys_src1), 32);
    chk("flush_dest", 32'(phys_dest), 33);
    tick();
    idle();
    chk("flush_count", 32'(free_count), 31);
    tick();

    // Commit and flush in the same cycle.
    do_reset();
    ren(0, 0, 7); tick();
    drive(0, 0, 0, 0, 0, 1, 1, 7, 32, 7, 1); tick();
    ren(7, 0, 2);
    chk("cf_src7",  32'(phys_src1), 32);
    chk("cf_count", 32'(free_count), 32);
    chk("cf_dest",  32'(phys_dest), 33);
    tick();

    // Asynchronous reset in the middle of a stream of allocations.
    do_reset();
    for (int i = 0; i < 10; i++) begin ren(0, 0, i + 1); tick(); end
    rename_valid = 0; rename_src1 = 5'd7; rename_src2 = 5'd9;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("areset_count", 32'(free_count), 32);
    chk("areset_err",   32'(overflow_err), 0);
    chk("areset_src1",  32'(phys_src1), 7);
    chk("areset_src2",  32'(phys_src2), 9);
    @(negedge clk);
    idle(); tick();
    reset = 1'b1;

    // Commit into a full list: sticky error, state untouched.
    drive(0, 0, 0, 0, 0, 1, 1, 3, 40, 3, 0); tick();
    idle();
    chk("ovf_set",   32'(overflow_err), 1);
    chk("ovf_count", 32'(free_count), 32);
    tick();
    repeat (3) begin idle(); tick(); end
    ren(3, 0, 3);
    chk("ovf_sticky", 32'(overflow_err), 1);
    chk("ovf_src3",   32'(phys_src1), 3);
    chk("ovf_dest",   32'(phys_dest), 32);
    tick();

    // Random traffic with ROB-ordered commits and occasional flushes.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      hd = ($urandom_range(0, 4) != 0);
      s1 = $urandom_range(0, 31);
      s2 = $urandom_range(0, 31);
      d  = $urandom_range(0, 31);
      cv = 0; chd = 0; ca = 0; cp = 0; co = 0;
      if (rob.size() > 0 && $urandom_range(0, 1) == 1) begin
        cv = 1; chd = 1; ca = rob[0].arch; cp = rob[0].np; co = rob[0].op;
      end else if ($urandom_range(0, 7) == 0) begin
        cv = 1; chd = $urandom_range(0, 1);
        ca = chd ? 0 : $urandom_range(1, 31);
        cp = $urandom_range(1, 63); co = $urandom_range(1, 63);
      end
      fl = ($urandom_range(0, 39) == 0);
      drive(v[0], hd[0], s1, s2, d, cv[0], chd[0], ca, cp, co, fl[0]);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
